sprite_table_writer: RTL

- CPU-side writer for the sprite/pattern RAM that the line sprite manager reads.
- Accepts 16-bit half-word writes from the Q16 CPU bus and assembles them into 32-bit RAM words.
- Queues assembled words in a small FIFO.
- Commits queued words to the RAM write port only during vertical blanking, so the manager's per-line attribute and pattern fetches never see a half-updated table.

---
 rtl/sprite_table_writer_if.sv | 42 ++++
 rtl/sprite_table_writer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_table_writer_if.sv
// ---------------------------------------------------------------------------
// sprite_table_writer_if
//
// CPU half-word write bus into the sprite table writer.
//
// Handshake: a transfer happens on a rising clk edge when cpu_wr=1 and
// cpu_ready=1. The master keeps cpu_addr/cpu_half/cpu_data stable while
// cpu_wr=1 and cpu_ready=0, and retries until it is accepted. There is one
// exception. A low half (cpu_half=0) only loads a holding latch, so it is
// accepted whenever cpu_wr=1, even if cpu_ready=0. cpu_ready gates the high
// half alone, because only the high half pushes into the FIFO.
//
// Signals:
//   cpu_wr    master->slave  write strobe, one cycle per half-word
//   cpu_addr  master->slave  9-bit RAM word address
//   cpu_half  master->slave  0 = bits [15:0], 1 = bits [31:16]
//   cpu_data  master->slave  16-bit half-word
//   cpu_ready slave->master  FIFO not full
// ---------------------------------------------------------------------------
interface sprite_table_writer_if;
  logic        cpu_wr;
  logic [8:0]  cpu_addr;
  logic        cpu_half;
  logic [15:0] cpu_data;
  logic        cpu_ready;

  modport master (
    output cpu_wr,
    output cpu_addr,
    output cpu_half,
    output cpu_data,
    input  cpu_ready
  );

  modport slave (
    input  cpu_wr,
    input  cpu_addr,
    input  cpu_half,
    input  cpu_data,
    output cpu_ready
  );
endinterface

// File: rtl/sprite_table_writer.sv
// ---------------------------------------------------------------------------
// sprite_table_writer
//
// CPU-side writer for the sprite/pattern RAM that the line sprite manager
// reads. The block assembles 16-bit half-word writes into 32-bit words and
// queues them in a FIFO. It commits the queued words to the RAM write port
// only while the raster is in vertical blank, so the manager never fetches a
// half-updated table.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, 2..32)
//   VIS_LINES  first CounterY line of vertical blank
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   CounterY    current raster line
//   cpu         CPU half-word write bus (slave side)
//   err         sticky flag: a high half arrived with no matching low half
//   err_clr     clears err; a new error in the same cycle wins
//   pending     FIFO occupancy, 0..DEPTH
//   ram_we      RAM write enable (registered)
//   ram_addr    RAM write address (holds its last value when idle)
//   ram_data    RAM write data (holds its last value when idle)
//   flush_done  one-cycle pulse when a blank-time pop empties the FIFO
// ---------------------------------------------------------------------------
module sprite_table_writer #(
  parameter int DEPTH     = 8,
  parameter int VIS_LINES = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8:0]               CounterY,
  sprite_table_writer_if.slave     cpu,
  output logic                     err,
  input  logic                     err_clr,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     ram_we,
  output logic [8:0]               ram_addr,
  output logic [31:0]              ram_data,
  output logic                     flush_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [8:0]    VIS_Y   = 9'(VIS_LINES);
  localparam logic [CW-1:0] FULL_CT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CT  = CW'(1);

  // FIFO entry layout: {addr[8:0], data[31:0]}
  logic [40:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Low-half holding latch
  logic [15:0]   lo_data;
  logic [8:0]    lo_addr;
  logic          lo_valid;

  logic          full;
  logic          empty;
  logic          win;
  logic          lo_accept;
  logic          hi_accept;
  logic          pair_ok;
  logic          push;
  logic          pop;
  logic          err_set;
  logic [40:0]   push_entry;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  assign full          = (count == FULL_CT);
  assign empty         = (count == '0);
  assign cpu.cpu_ready = !full;

  // The window is sampled every cycle, so draining stops on the very cycle
  // the raster leaves blank.
  assign win = (CounterY >= VIS_Y);

  assign lo_accept = cpu.cpu_wr && !cpu.cpu_half;
  assign hi_accept = cpu.cpu_wr &&  cpu.cpu_half && !full;

  // A high half pairs with the latch only when the latch holds a low half
  // for the same word address. Otherwise the word goes out with a zero low
  // half and the error is flagged.
  assign pair_ok = lo_valid && (lo_addr == cpu.cpu_addr);
  assign err_set = hi_accept && !pair_ok;

  always_comb begin
    push_entry = {cpu.cpu_addr, cpu.cpu_data, 16'h0000};
    if (pair_ok) begin
      push_entry = {cpu.cpu_addr, cpu.cpu_data, lo_data};
    end
  end

  assign push = hi_accept;
  assign pop  = win && !empty;

  assign pending = count;

  // ---------------------------------------------------------------------------
  // Low-half latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_data  <= '0;
      lo_addr  <= '0;
      lo_valid <= 1'b0;
    end else if (lo_accept) begin
      lo_data  <= cpu.cpu_data;
      lo_addr  <= cpu.cpu_addr;
      lo_valid <= 1'b1;
    end else if (hi_accept) begin
      // The latch is consumed by any accepted high half, paired or orphaned.
      lo_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage. Reset does not clear it: clearing the pointers empties it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + ONE_CT;
        2'b01:   count <= count - ONE_CT;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port. The address and data hold between writes, so the RAM
  // side sees a stable bus while ram_we is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      flush_done <= 1'b0;
    end else begin
      ram_we     <= pop;
      // Empty after this edge only if the last entry leaves and none arrives.
      flush_done <= pop && !push && (count == ONE_CT);
      if (pop) begin
        {ram_addr, ram_data} <= mem[rd_ptr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flag. When a set and a clear arrive in the same cycle, the
  // set wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule
